pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencing unit for the 5-stage RV32 core. It drives the hold and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers. It detects load-use hazards, holds the pipe during multi-cycle data-memory accesses, and flushes wrong-path instructions on a taken branch. It also keeps saturating stall and flush performance counters and raises a sticky memory-timeout flag.

Parameters:
MEM_TIMEOUT, 255, max consecutive wait cycles in MEM_WAIT before entering TRAP (1..2^CNT_W-1)
CNT_W, 16, width of the wait counter and both performance counters

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_rs1  input  5  rs1 index of the instruction in ID
id_rs2  input  5  rs2 index of the instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
ex_rd  input  5  destination index of the instruction in EX
ex_read_en  input  1  EX instruction is a load
mem_read_en  input  1  MEM-stage load access active
mem_update_en  input  1  MEM-stage store access active
dmem_ready  input  1  data memory completes access this cycle
branch_taken  input  1  taken-branch/jump indication from the EX/MEM register
stall_pc  output  1  hold PC
stall_ifid  output  1  hold IF/ID
stall_idex  output  1  hold ID/EX
stall_exmem  output  1  hold EX/MEM
flush_ifid  output  1  clear IF/ID to NOP
bubble_idex  output  1  load NOP into ID/EX
mem_timeout  output  1  sticky timeout flag, registered
stall_cnt  output  CNT_W  cycles with stall_pc=1, saturating
flush_cnt  output  CNT_W  cycles with flush_ifid=1, saturating

Behaviour:
- Reset (async, rst_n=0): state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0. With all inputs 0, every combinational output is 0.
- Control outputs are combinational from the state register and the current inputs, with zero latency. mem_timeout and the counters are registered and update on the rising edge.
- mem_busy = (mem_read_en|mem_update_en) & ~dmem_ready.
- load_use = ex_read_en & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- FSM states: RUN, MEM_WAIT, TRAP.
- RUN / MEM_WAIT, priority order, first match wins:
  1. mem_busy: assert all four stall_* outputs; flush_ifid=0; bubble_idex=0. Branch and load-use handling is deferred because EX/MEM holds, so the cause persists.
  2. branch_taken: flush_ifid=1, bubble_idex=1, stalls=0. A concurrent load_use is suppressed because the ID instruction is wrong-path.
  3. load_use: stall_pc=1, stall_ifid=1, bubble_idex=1, stall_idex=0, stall_exmem=0. This lasts exactly 1 cycle because the load advances.
  4. Otherwise all control outputs are 0.
- Transitions:
  - RUN -> MEM_WAIT when mem_busy; wait_cnt is set to 1.
  - MEM_WAIT stays while mem_busy; wait_cnt increments each cycle.
  - MEM_WAIT -> RUN in the cycle dmem_ready=1; the stall drops in that same cycle and wait_cnt clears.
  - MEM_WAIT -> TRAP when mem_busy and wait_cnt==MEM_TIMEOUT.
- TRAP: all four stall_* held at 1, flush/bubble 0, mem_timeout=1 from the next edge. TRAP is left only by reset; a reset mid-wait or in TRAP returns to RUN immediately.
- A zero-wait access (access asserted with dmem_ready=1 in the same cycle) causes no stall and no state change.
- Counters saturate at 2^CNT_W-1 and never wrap. A stall and a flush cannot both count in the same cycle, given the priority order.
- ex_rd=0 never triggers load_use. An unused source operand never triggers load_use.

Test Plan:
- Load-use: ex_read_en=1, ex_rd=5, id_rs2=5, id_rs2_used=1 for 1 cycle -> stall_pc=stall_ifid=bubble_idex=1 for exactly that cycle, stall_exmem=0, stall_cnt 0->1. Repeat with ex_rd=0 -> no stall.
- Memory wait: mem_read_en=1, dmem_ready=0 for 3 cycles then 1 -> all stalls=1 for 3 cycles, 0 on the ready cycle, state back to RUN, stall_cnt=3.
- Branch flush with concurrent load-use: branch_taken=1 plus a load_use match -> flush_ifid=1, bubble_idex=1, stall_pc=0, flush_cnt=1.
- Timeout: MEM_TIMEOUT=4, mem_update_en=1, dmem_ready held at 0 -> TRAP entered after 4 wait cycles, mem_timeout=1 on the next edge, stalls stay 1 after dmem_ready later rises; rst_n pulse -> all outputs 0.
- Saturation: CNT_W=3, hold mem_busy for 10 cycles -> stall_cnt stops at 7.
- Async reset mid-MEM_WAIT: drop rst_n between clock edges -> outputs go to 0 without waiting for a clock edge, wait_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing for the 5-stage RV32 core: load-use interlock, data-memory wait
// hold, taken-branch flush, memory-timeout trap and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_read_en,
    input  logic             mem_read_en,
    input  logic             mem_update_en,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_exmem,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        TRAP
    } state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             mem_busy;
    logic             load_use;

    assign mem_busy = (mem_read_en | mem_update_en) & ~dmem_ready;
    assign load_use = ex_read_en & (ex_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) |
                       (id_rs2_used & (id_rs2 == ex_rd)));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    // Branch/load-use stay pending: EX/MEM holds, so their cause persists.
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    stall_idex  = 1'b1;
                    stall_exmem = 1'b1;
                    if (state_q == RUN) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = CNT_W'(1);
                    end else if (wait_cnt_q == TIMEOUT_V) begin
                        state_d = TRAP;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (branch_taken) begin
                        flush_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                    end else if (load_use) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                    end
                end
            end
            TRAP: begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                stall_idex  = 1'b1;
                stall_exmem = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_q == TRAP) begin
                mem_timeout_q <= 1'b1;
            end
            if (stall_pc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_ifid && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: main instance (MEM_TIMEOUT=4, CNT_W=16) and a
// narrow-counter instance (MEM_TIMEOUT=7, CNT_W=3) sharing the same stimulus.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_read_en;
    logic       mem_read_en, mem_update_en, dmem_ready, branch_taken;

    logic        stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, bubble_idex;
    logic        mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc, s_ifid, s_idex, s_exmem, f_ifid, b_idex, mto2;
    logic [2:0]  stall_cnt2, flush_cnt2;

    logic [5:0] ctl;
    assign ctl = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, bubble_idex};

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_read_en(ex_read_en),
        .mem_read_en(mem_read_en), .mem_update_en(mem_update_en), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(7), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_read_en(ex_read_en),
        .mem_read_en(mem_read_en), .mem_update_en(mem_update_en), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken),
        .stall_pc(s_pc), .stall_ifid(s_ifid), .stall_idex(s_idex),
        .stall_exmem(s_exmem), .flush_ifid(f_ifid), .bubble_idex(b_idex),
        .mem_timeout(mto2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_read_en = 1'b0;
        mem_read_en = 1'b0; mem_update_en = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #3;
        check("rst_ctl", 32'(ctl), 32'h0);
        check("rst_mto", 32'(mem_timeout), 32'h0);
        check("rst_scnt", 32'(stall_cnt), 32'h0);
        check("rst_fcnt", 32'(flush_cnt), 32'h0);
        check("rst_scnt2", 32'(stall_cnt2), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Load-use on rs2
        ex_read_en = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
        #1 check("lu_rs2_ctl", 32'(ctl), 32'b110001);
        tick();
        check("lu_rs2_scnt", 32'(stall_cnt), 32'd1);
        clear_inputs();
        #1 check("lu_one_cycle", 32'(ctl), 32'h0);

        // ex_rd = 0 never interlocks
        ex_read_en = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_used = 1'b1;
        #1 check("lu_x0_ctl", 32'(ctl), 32'h0);
        tick();
        check("lu_x0_scnt", 32'(stall_cnt), 32'd1);

        // Matching but unused operand
        clear_inputs();
        ex_read_en = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs2 = 5'd9;
        #1 check("lu_unused_ctl", 32'(ctl), 32'h0);
        id_rs1_used = 1'b1;
        #1 check("lu_rs1_ctl", 32'(ctl), 32'b110001);
        tick();
        check("lu_rs1_scnt", 32'(stall_cnt), 32'd2);
        clear_inputs();

        // Three-cycle memory wait
        mem_read_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("mw_stall_ctl", 32'(ctl), 32'b111100);
            tick();
        end
        dmem_ready = 1'b1;
        #1 check("mw_ready_ctl", 32'(ctl), 32'h0);
        tick();
        check("mw_scnt", 32'(stall_cnt), 32'd5);
        check("mw_wait_clr", 32'(dut.wait_cnt_q), 32'h0);

        // Zero-wait access
        #1 check("zw_ctl", 32'(ctl), 32'h0);
        tick();
        check("zw_scnt", 32'(stall_cnt), 32'd5);
        check("zw_wait", 32'(dut.wait_cnt_q), 32'h0);
        clear_inputs();

        // Branch with concurrent load-use
        branch_taken = 1'b1; ex_read_en = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
        #1 check("br_lu_ctl", 32'(ctl), 32'b000011);
        tick();
        check("br_fcnt", 32'(flush_cnt), 32'd1);
        check("br_scnt", 32'(stall_cnt), 32'd5);
        clear_inputs();

        // Memory busy outranks branch; branch acts on the ready cycle
        branch_taken = 1'b1; mem_read_en = 1'b1;
        #1 check("busy_br_ctl", 32'(ctl), 32'b111100);
        tick();
        dmem_ready = 1'b1;
        #1 check("rdy_br_ctl", 32'(ctl), 32'b000011);
        tick();
        check("busy_br_fcnt", 32'(flush_cnt), 32'd2);
        check("busy_br_scnt", 32'(stall_cnt), 32'd6);
        clear_inputs();

        // Timeout: RUN->MEM_WAIT, four MEM_WAIT cycles, then TRAP
        mem_update_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check("to_wait_ctl", 32'(ctl), 32'b111100);
            check("to_wait_mto", 32'(mem_timeout), 32'h0);
            tick();
        end
        dmem_ready = 1'b1;
        #1 check("trap_hold_ctl", 32'(ctl), 32'b111100);
        tick();
        check("trap_mto", 32'(mem_timeout), 32'h1);
        check("trap_scnt", 32'(stall_cnt), 32'd12);
        #1 check("trap_stay_ctl", 32'(ctl), 32'b111100);
        #2 rst_n = 1'b0;
        #1 check("trap_rst_ctl", 32'(ctl), 32'h0);
        check("trap_rst_mto", 32'(mem_timeout), 32'h0);
        check("trap_rst_scnt", 32'(stall_cnt), 32'h0);
        check("trap_rst_fcnt", 32'(flush_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        tick();

        // Async reset mid-wait
        mem_read_en = 1'b1;
        tick();
        tick();
        check("mid_wait_cnt", 32'(dut.wait_cnt_q), 32'd2);
        #2;
        rst_n = 1'b0;
        clear_inputs();
        #1 check("mid_rst_ctl", 32'(ctl), 32'h0);
        check("mid_rst_wait", 32'(dut.wait_cnt_q), 32'h0);
        check("mid_rst_scnt", 32'(stall_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Saturation on the 3-bit counter instance
        mem_read_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("sat_scnt2", 32'(stall_cnt2), (i < 7) ? 32'(i) : 32'd7);
        end
        check("sat_fcnt2", 32'(flush_cnt2), 32'h0);
        check("sat_main_scnt", 32'(stall_cnt), 32'd10);
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
